// File: rtl/nic_port_mapper_if.sv
// Word-stream bundle (data, ctrl, write strobe, ready) between NIC pipeline stages.
// The master drives data/ctrl/wr; the slave returns rdy.
interface nic_port_mapper_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] data;
    logic [CTRL_WIDTH-1:0] ctrl;
    logic                  wr;
    logic                  rdy;

    modport master (output data, ctrl, wr, input rdy);
    modport slave  (input data, ctrl, wr, output rdy);
endinterface

// File: rtl/nic_port_mapper.sv
// Purpose: rewrites the IOQ destination field from source port and mode, and discards packets from invalid sources.
// Latency: one write cycle into the output FIFO; out_wr is registered one cycle after each FIFO read.
// Backpressure: in_rdy drops when the FIFO has one free entry; reads only while out_rdy. Option: NIC_PORT_MAPPER_DROP_CNT_EN adds drop_count.
`ifndef IO_QUEUE_STAGE_NUM
`define IO_QUEUE_STAGE_NUM 8'hff
`endif
`ifndef IOQ_SRC_PORT_POS
`define IOQ_SRC_PORT_POS 16
`endif
`ifndef IOQ_DST_PORT_POS
`define IOQ_DST_PORT_POS 0
`endif

module nic_port_mapper_fifo #(
    parameter int WIDTH      = 72,
    parameter int DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_dat,
    output logic             empty,
    output logic             nearly_full
);
    localparam logic [DEPTH_BITS:0] DEPTH = (DEPTH_BITS + 1)'(1 << DEPTH_BITS);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_BITS-1:0] wptr;
    logic [DEPTH_BITS-1:0] rptr;
    logic [DEPTH_BITS:0]   cnt;
    logic                  full;
    logic                  rd_ok;
    logic                  wr_ok;

    assign full        = (cnt == DEPTH);
    assign empty       = (cnt == '0);
    assign nearly_full = (cnt >= DEPTH - 1'b1);
    assign rd_ok       = rd_en && !empty;
    // A write at full depth is still safe when the same edge frees a slot.
    assign wr_ok       = wr_en && (!full || rd_ok);
    assign rd_dat      = mem[rptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) rptr <= rptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module nic_port_mapper #(
    parameter int                    DATA_WIDTH         = 64,
    parameter int                    CTRL_WIDTH         = DATA_WIDTH / 8,
    parameter int                    NUM_MAC_PORTS      = 4,
    parameter logic [CTRL_WIDTH-1:0] IO_QUEUE_STAGE_NUM = `IO_QUEUE_STAGE_NUM,
    parameter int                    FIFO_DEPTH_BITS    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    nic_port_mapper_if.slave         in_bus,
    nic_port_mapper_if.master        out_bus,
    input  logic [1:0]               mode,
    output logic [31:0]              pkt_count
`ifdef NIC_PORT_MAPPER_DROP_CNT_EN
    ,
    output logic [31:0]              drop_count
`endif
);
    localparam logic [1:0] ST_HDRS = 2'd0;
    localparam logic [1:0] ST_PKT  = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]                       state;
    logic                             drop_seen_pl;
    logic [31:0]                      pkt_cnt_q;
    logic [15:0]                      src;
    logic                             is_ioq;
    logic                             ctrl_zero;
    logic                             src_valid;
    logic                             ioq_hit;
    logic [3:0]                       dst_bit;
    logic [DATA_WIDTH-1:0]            mapped;
    logic                             fifo_wr;
    logic                             fifo_rd;
    logic                             fifo_empty;
    logic                             fifo_nearly_full;
    logic [CTRL_WIDTH+DATA_WIDTH-1:0] fifo_wr_dat;
    logic [CTRL_WIDTH+DATA_WIDTH-1:0] fifo_rd_dat;

    assign src       = in_bus.data[`IOQ_SRC_PORT_POS+15:`IOQ_SRC_PORT_POS];
    assign is_ioq    = (in_bus.ctrl == IO_QUEUE_STAGE_NUM);
    assign ctrl_zero = (in_bus.ctrl == '0);
    assign src_valid = (src < 16'(2 * NUM_MAC_PORTS));
    assign ioq_hit   = in_bus.wr && (state == ST_HDRS) && is_ioq;

    // Even sources are MAC ports, odd sources are the paired CPU queues.
    always_comb begin
        dst_bit = '0;
        case (mode)
            2'd1:    dst_bit = src[3:0];
            2'd2:    dst_bit = src[0] ? src[3:0] - 4'd1 : 4'd1;
            default: dst_bit = src[0] ? src[3:0] - 4'd1 : src[3:0] + 4'd1;
        endcase
        mapped = in_bus.data;
        mapped[`IOQ_DST_PORT_POS +: 16] = 16'd1 << dst_bit;
    end

    always_comb begin
        fifo_wr = 1'b0;
        if (in_bus.wr) begin
            case (state)
                ST_HDRS: fifo_wr = !(is_ioq && !src_valid);
                ST_PKT:  fifo_wr = 1'b1;
                default: fifo_wr = 1'b0;
            endcase
        end
    end

    assign fifo_wr_dat = {in_bus.ctrl, (ioq_hit && src_valid) ? mapped : in_bus.data};

    // DROP must see payload before a nonzero ctrl word can be the EOP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_HDRS;
            drop_seen_pl <= 1'b0;
        end else if (in_bus.wr) begin
            case (state)
                ST_HDRS: begin
                    if (is_ioq && !src_valid) begin
                        state        <= ST_DROP;
                        drop_seen_pl <= 1'b0;
                    end else if (ctrl_zero) begin
                        state <= ST_PKT;
                    end
                end
                ST_PKT: begin
                    if (!ctrl_zero) state <= ST_HDRS;
                end
                ST_DROP: begin
                    if (ctrl_zero)         drop_seen_pl <= 1'b1;
                    else if (drop_seen_pl) state        <= ST_HDRS;
                end
                default: state <= ST_HDRS;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_cnt_q <= '0;
        end else if (ioq_hit && src_valid && (pkt_cnt_q != '1)) begin
            pkt_cnt_q <= pkt_cnt_q + 32'd1;
        end
    end
    assign pkt_count = pkt_cnt_q;

`ifdef NIC_PORT_MAPPER_DROP_CNT_EN
    logic [31:0] drop_cnt_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else if (ioq_hit && !src_valid && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + 32'd1;
        end
    end
    assign drop_count = drop_cnt_q;
`endif

    nic_port_mapper_fifo #(
        .WIDTH      (CTRL_WIDTH + DATA_WIDTH),
        .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (fifo_wr),
        .wr_dat      (fifo_wr_dat),
        .rd_en       (fifo_rd),
        .rd_dat      (fifo_rd_dat),
        .empty       (fifo_empty),
        .nearly_full (fifo_nearly_full)
    );

    assign in_bus.rdy = !fifo_nearly_full;
    assign fifo_rd    = out_bus.rdy && !fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_bus.wr   <= 1'b0;
            out_bus.data <= '0;
            out_bus.ctrl <= '0;
        end else begin
            out_bus.wr <= fifo_rd;
            if (fifo_rd) begin
                {out_bus.ctrl, out_bus.data} <= fifo_rd_dat;
            end
        end
    end
endmodule

// File: doc/nic_port_mapper.md
NIC_PORT_MAPPER -- requirements
Module: nic_port_mapper

Interface
REQ-001 Parameter DATA_WIDTH, default 64: datapath width in bits.
REQ-002 Parameter CTRL_WIDTH, default DATA_WIDTH/8: control width in bits.
REQ-003 Parameter NUM_MAC_PORTS, default 4, legal range 1..8: number of MAC/CPU port pairs; valid source indices are 0..2*NUM_MAC_PORTS-1.
REQ-004 Parameter IO_QUEUE_STAGE_NUM, default `IO_QUEUE_STAGE_NUM: ctrl value that marks the IOQ module-header word.
REQ-005 Parameter FIFO_DEPTH_BITS, default 2: output FIFO depth is 2**FIFO_DEPTH_BITS words.
REQ-006 clk  in  1  single clock; all logic is on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 in_data/in_ctrl/in_wr  in  DATA_WIDTH/CTRL_WIDTH/1  upstream word, ctrl, write strobe.
REQ-009 in_rdy  out  1  upstream may write next cycle.
REQ-010 out_data/out_ctrl/out_wr  out  DATA_WIDTH/CTRL_WIDTH/1  downstream word, ctrl, write strobe.
REQ-011 out_rdy  in  1  downstream may accept a word.
REQ-012 mode  in  2  routing mode: 0 NIC crossover, 1 loopback, 2 aggregate-to-CPU0, 3 treated as 0.
REQ-013 pkt_count  out  32  packets forwarded since reset.

Function
REQ-014 Packet framing: the IOQ word (in_ctrl==IO_QUEUE_STAGE_NUM) is the first word of every packet; remaining headers carry nonzero ctrl; payload has ctrl==0; the first nonzero-ctrl word after payload is EOP.
REQ-015 FSM states: HDRS (reset state), PKT, DROP.
REQ-016 HDRS -> PKT on an accepted ctrl==0 word; PKT -> HDRS on an accepted nonzero-ctrl word; HDRS -> DROP on an IOQ word with invalid source; DROP -> HDRS on the EOP word.
REQ-017 Source index src = in_data[`IOQ_SRC_PORT_POS+15:`IOQ_SRC_PORT_POS]; odd src = CPU, even src = MAC.
REQ-018 On an IOQ word in HDRS with valid src, in_data[`IOQ_DST_PORT_POS+15:`IOQ_DST_PORT_POS] is replaced by a one-hot field; all other bits pass unchanged.
REQ-019 Mode 0: CPU src 2k+1 -> bit 2k; MAC src 2k -> bit 2k+1.
REQ-020 Mode 1: destination bit = src.
REQ-021 Mode 2: MAC src -> bit 1; CPU src as mode 0.
REQ-022 mode is sampled on the IOQ word only; a change mid-packet does not affect that packet.
REQ-023 src >= 2*NUM_MAC_PORTS: the whole packet (IOQ word through EOP) is discarded; no word enters the FIFO.
REQ-024 Non-IOQ words in HDRS/PKT are written to the FIFO unmodified.
REQ-025 in_rdy = !fifo_nearly_full, with nearly_full asserted at one free entry; a word written while in_rdy=0 is a protocol violation and its handling is unspecified.
REQ-026 fifo_rd_en = out_rdy && !fifo_empty; out_wr is registered fifo_rd_en, so data appears one cycle after the read.
REQ-027 Output order equals input order; simultaneous FIFO read and write at full depth neither overflows nor loses a word.
REQ-028 pkt_count increments by 1 on each accepted valid IOQ word, saturates at 0xFFFFFFFF, and does not wrap.

Reset
REQ-029 While reset=1: state=HDRS, FIFO empty, out_wr=0, pkt_count=0, drop_count=0; in_rdy=1 from the first cycle after reset.
REQ-030 Reset mid-packet discards the partial packet; the next word is treated as a packet start.

Configuration
REQ-031 Macro NIC_PORT_MAPPER_DROP_CNT_EN: when defined, adds output drop_count (out, 32), incremented by 1 per discarded packet and saturating at 0xFFFFFFFF; when undefined, the port and counter are absent and dropping is unchanged.

Verification
REQ-032 Mode 0, NUM_MAC_PORTS=4, IOQ word with src=3 -> out dst field 0x0004, other bits equal; src=4 -> 0x0020.
REQ-033 Mode 1, src=5 -> dst 0x0020; mode 2, src=6 -> dst 0x0002; mode toggled 2->0 mid-payload -> that packet keeps dst 0x0002.
REQ-034 src=9 with NUM_MAC_PORTS=4, 6-word packet -> no out_wr for any of its words, pkt_count unchanged, drop_count +1 (macro defined); following valid packet forwarded intact.
REQ-035 out_rdy held 0 while 10 words are offered -> in_rdy drops after 3 words (depth 4); out_rdy=1 -> all words emerge in order, out_wr one cycle after each read.
REQ-036 Reset asserted on the 3rd payload word -> out_wr=0 and pkt_count=0 the next cycle; next packet is mapped correctly.
REQ-037 pkt_count preloaded to 0xFFFFFFFE, 3 valid packets -> pkt_count reads 0xFFFFFFFF.
